// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: each stage retires GROUPS_PER_STAGE
// 4-bit lookahead groups, with the chunk carry registered into the next stage.

module cla_pipe_adder_grp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic [4:1] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ {c[3:1], ci};
    co   = c[4];
  end
endmodule

module cla_pipe_adder_chunk #(
  parameter int GROUPS = 2
) (
  input  logic [4*GROUPS-1:0] a,
  input  logic [4*GROUPS-1:0] b,
  input  logic                ci,
  output logic [4*GROUPS-1:0] s,
  output logic                co
);
  logic [GROUPS:0] c;

  assign c[0] = ci;
  assign co   = c[GROUPS];

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    cla_pipe_adder_grp u_grp (
      .a (a[4*g +: 4]),
      .b (b[4*g +: 4]),
      .ci(c[g]),
      .s (s[4*g +: 4]),
      .co(c[g+1])
    );
  end
endmodule

module cla_pipe_adder #(
  parameter int WIDTH            = 32,
  parameter int GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);
  localparam int CW     = 4 * GROUPS_PER_STAGE;
  localparam int STAGES = WIDTH / CW;

  logic [WIDTH-1:0]  bx;
  logic              cin0;
  logic [STAGES-1:0] vld_d, vld_q, adv, free, lv;

  assign bx   = sub ? ~b : b;
  assign cin0 = sub | carry_in;

  // free[k]: stage k can take a beat this cycle; resolved from the output back
  // so a full pipeline draining at the tail still shifts every stage.
  always_comb begin
    adv  = '0;
    free = '0;
    lv   = '0;
    free[STAGES-1] = !vld_q[STAGES-1] || out_ready;
    for (int k = STAGES - 1; k >= 1; k--) begin
      adv[k]    = vld_q[k-1] && free[k];
      free[k-1] = !vld_q[k-1] || adv[k];
    end
    adv[0] = in_valid && free[0];
    lv[STAGES-1] = vld_q[STAGES-1] && out_ready;
    for (int k = 0; k < STAGES - 1; k++) lv[k] = adv[k+1];
    vld_d = adv | (vld_q & ~lv);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  assign in_ready  = free[0];
  assign out_valid = vld_q[STAGES-1];
  assign busy      = |vld_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [CW-1:0]       ca, cb, cs;
    logic                ci, co;
    logic [CW*(k+1)-1:0] sum_nx, sum_d, sum_q;
    logic                cy_d, cy_q;

    if (k == 0) begin : g_in
      assign ca     = a[CW-1:0];
      assign cb     = bx[CW-1:0];
      assign ci     = cin0;
      assign sum_nx = cs;
    end else begin : g_in
      assign ca     = g_stg[k-1].g_rem.a_q[CW-1:0];
      assign cb     = g_stg[k-1].g_rem.b_q[CW-1:0];
      assign ci     = g_stg[k-1].cy_q;
      assign sum_nx = {cs, g_stg[k-1].sum_q};
    end

    cla_pipe_adder_chunk #(.GROUPS(GROUPS_PER_STAGE)) u_chunk (
      .a (ca),
      .b (cb),
      .ci(ci),
      .s (cs),
      .co(co)
    );

    always_comb begin
      sum_d = sum_q;
      cy_d  = cy_q;
      if (adv[k]) begin
        sum_d = sum_nx;
        cy_d  = co;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sum_q <= '0;
        cy_q  <= 1'b0;
      end else begin
        sum_q <= sum_d;
        cy_q  <= cy_d;
      end
    end

    // Operand bits not yet consumed travel with the beat; b is already inverted.
    if (k < STAGES - 1) begin : g_rem
      localparam int RW = WIDTH - CW * (k + 1);
      logic [RW-1:0] a_src, b_src, a_d, a_q, b_d, b_q;

      if (k == 0) begin : g_src
        assign a_src = a[WIDTH-1:CW];
        assign b_src = bx[WIDTH-1:CW];
      end else begin : g_src
        assign a_src = g_stg[k-1].g_rem.a_q[RW+CW-1:CW];
        assign b_src = g_stg[k-1].g_rem.b_q[RW+CW-1:CW];
      end

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv[k]) begin
          a_d = a_src;
          b_d = b_src;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_fin
      logic cm_d, cm_q;

      // Carry into the MSB recovered from the MSB half-sum and result bit.
      always_comb begin
        cm_d = cm_q;
        if (adv[k]) cm_d = ca[CW-1] ^ cb[CW-1] ^ cs[CW-1];
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) cm_q <= 1'b0;
        else        cm_q <= cm_d;
      end

      assign sum       = sum_q;
      assign carry_out = cy_q;
      assign overflow  = cm_q ^ cy_q;
    end
  end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Randomized scoreboard bench for cla_pipe_adder: arithmetic reference model,
// in-flight occupancy model for in_ready/busy, latency and hold-stability checks.

module tb_cla_pipe_adder;
  localparam int W   = 32;
  localparam int GPS = 2;
  localparam int S   = W / (4 * GPS);

  logic         clk, reset;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         carry_in, sub, carry_out, overflow, busy;

  cla_pipe_adder #(.WIDTH(W), .GROUPS_PER_STAGE(GPS)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry_out(carry_out),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           acc_cyc;
    bit           seen;
  } beat_t;

  beat_t        q[$];
  int           n_err = 0, n_chk = 0, cyc = 0;
  bit           exact_lat, hold;
  logic [W-1:0] hsum;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic beat_t model(input logic [W-1:0] ia, ib, input logic ci, isub);
    beat_t  e;
    longint ua, ub, sa, sb, u, sv, smax, smin;
    ua   = longint'(ia);
    ub   = longint'(ib);
    sa   = longint'($signed(ia));
    sb   = longint'($signed(ib));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    if (isub) begin
      u    = ua - ub;
      e.co = (ua >= ub);
      sv   = sa - sb;
    end else begin
      u    = ua + ub + longint'(ci);
      e.co = u[W];
      sv   = sa + sb + longint'(ci);
    end
    e.s       = u[W-1:0];
    e.ov      = (sv > smax) || (sv < smin);
    e.acc_cyc = 0;
    e.seen    = 0;
    return e;
  endfunction

  // One clock: observe at the falling edge, update the model, return after posedge.
  task automatic step(output bit acc);
    bit    drn;
    beat_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    chk("in_ready", in_ready, (q.size() < S) || out_ready);
    chk("busy", busy, q.size() != 0);
    if (hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", sum, hsum);
    end
    if (out_valid) begin
      if (q.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        if (!q[0].seen) begin
          q[0].seen = 1;
          if (exact_lat) chk("latency", cyc - 1 - q[0].acc_cyc, S - 1);
        end
        chk("sum", sum, q[0].s);
        chk("carry_out", carry_out, q[0].co);
        chk("overflow", overflow, q[0].ov);
      end
    end
    hold = out_valid && !out_ready;
    hsum = sum;
    if (drn && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      e = model(a, b, carry_in, sub);
      e.acc_cyc = cyc;
      q.push_back(e);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ia, ib, input logic ci, isub);
    bit acc = 0;
    in_valid = 1; a = ia; b = ib; carry_in = ci; sub = isub;
    for (int i = 0; i < 10 && !acc; i++) step(acc);
    chk("send_accept", acc, 1);
    in_valid = 0;
  endtask

  task automatic wait_out();
    bit acc;
    for (int i = 0; i < 12 && !out_valid; i++) step(acc);
    chk("wait_out_valid", out_valid, 1);
  endtask

  task automatic drain();
    bit acc;
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 4 * S + 8 && q.size() > 0; i++) step(acc);
    chk("drain_empty", q.size(), 0);
    step(acc);
  endtask

  task automatic directed(input logic [W-1:0] ia, ib, input logic ci, isub,
                          input logic [W-1:0] es, input logic eco, eov);
    bit acc;
    out_ready = 0;
    send(ia, ib, ci, isub);
    wait_out();
    chk("dir_sum", sum, es);
    chk("dir_cout", carry_out, eco);
    chk("dir_ovf", overflow, eov);
    out_ready = 1;
    step(acc);
    out_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           acc;
    int           idx;
    logic [W-1:0] bpa[6];

    reset = 0; in_valid = 0; out_ready = 0;
    a = '0; b = '0; carry_in = 0; sub = 0;
    exact_lat = 1; hold = 0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", carry_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1;

    directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    directed(32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed(32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed(32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

    // Streaming at full throughput.
    out_ready = 1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1; a = $urandom; b = $urandom;
      carry_in = 1'($urandom); sub = 1'($urandom);
      step(acc);
      chk("stream_accept", acc, 1);
    end
    drain();

    // Backpressure: 6 beats offered into a stalled pipeline.
    exact_lat = 0;
    out_ready = 0;
    for (int i = 0; i < 6; i++) bpa[i] = $urandom;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; a = bpa[idx]; b = 32'(idx) + 1; carry_in = 0; sub = 0;
      step(acc);
      if (acc) idx++;
    end
    chk("bp_accepted", idx, S);
    for (int i = 0; i < 3; i++) step(acc);
    out_ready = 1;
    for (int i = 0; i < 20 && idx < 6; i++) begin
      in_valid = 1; a = bpa[idx]; b = 32'(idx) + 1; carry_in = 0; sub = 0;
      step(acc);
      if (acc) idx++;
    end
    chk("bp_all_sent", idx, 6);
    drain();

    // Random valid/ready with bubbles.
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      a = $urandom; b = $urandom; carry_in = 1'($urandom); sub = 1'($urandom);
      step(acc);
    end
    drain();

    // Asynchronous reset with 3 beats in flight.
    exact_lat = 1;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; a = $urandom | 32'h1; b = $urandom; carry_in = 0; sub = 0;
      step(acc);
    end
    in_valid = 0;
    #3;
    reset = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", carry_out, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    q.delete();
    hold = 0;
    @(posedge clk); #1;
    reset = 1;
    directed(32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
